// File: rtl/bcd_alarm_clock_multi.sv
// BCD time-of-day clock (HH:MM:SS, 24 h) with N programmable alarm channels
// and a ring / snooze / stop state machine with automatic ring timeout.
module bcd_alarm_clock_multi #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int N_ALARMS      = 4,
    parameter int SNOOZE_SEC    = 300,
    parameter int RING_SEC      = 60,
    localparam int IDX_W        = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                time_load,
    input  logic [15:0]         time_init_bcd,
    input  logic                alarm_wr,
    input  logic [IDX_W-1:0]    alarm_wr_idx,
    input  logic [15:0]         alarm_wr_bcd,
    input  logic [N_ALARMS-1:0] alarm_en,
    input  logic                snooze,
    input  logic                stop,
    output logic [15:0]         time_now_bcd,
    output logic [7:0]          sec_now_bcd,
    output logic                sec_tick,
    output logic                ring,
    output logic                snoozed,
    output logic [IDX_W-1:0]    ring_idx,
    output logic                cfg_err
);

    localparam int PW      = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int TMR_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int TW      = $clog2(TMR_MAX + 1);

    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0] RING_LD    = TW'(RING_SEC);
    localparam logic [TW-1:0] SNOOZE_LD  = TW'(SNOOZE_SEC);
    localparam logic [TW-1:0] TMR_ONE    = TW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    // HHMM packed as four BCD digits; hours limited to 00..23
    function automatic logic hhmm_ok(input logic [15:0] v);
        logic [3:0] hd, ho, md, mo;
        hd = v[15:12];
        ho = v[11:8];
        md = v[7:4];
        mo = v[3:0];
        return (hd <= 4'd2) && (ho <= 4'd9) && (md <= 4'd5) && (mo <= 4'd9)
            && !((hd == 4'd2) && (ho > 4'd3));
    endfunction

    logic [PW-1:0] presc;
    logic [3:0]    hd, ho, md, mo, sd, so;
    logic [3:0]    n_hd, n_ho, n_md, n_mo, n_sd, n_so;
    logic [15:0]   alarm_reg [N_ALARMS];
    logic          load_ok;
    logic          wr_ok;
    logic          roll_vld_p1;
    logic [N_ALARMS-1:0] hit;
    logic          hit_any;
    logic [IDX_W-1:0] hit_idx;

    state_t        state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic [IDX_W-1:0] idx_nxt;

    assign sec_tick     = (presc == PRESC_MAX);
    assign load_ok      = time_load && hhmm_ok(time_init_bcd);
    // Writes to a non-existent channel are rejected like malformed values
    assign wr_ok        = alarm_wr && hhmm_ok(alarm_wr_bcd)
                          && (32'(alarm_wr_idx) < 32'(N_ALARMS));
    assign time_now_bcd = {hd, ho, md, mo};
    assign sec_now_bcd  = {sd, so};
    assign ring         = (state == RINGING);
    assign snoozed      = (state == SNOOZED);

    // Prescaler: free-running 0..TICKS_PER_SEC-1, restarted by a valid load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (load_ok || sec_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Next time-of-day, digit-wise BCD increment with cascaded carries
    always_comb begin
        n_so = so + 4'd1;
        n_sd = sd;
        n_mo = mo;
        n_md = md;
        n_ho = ho;
        n_hd = hd;
        if (so == 4'd9) begin
            n_so = 4'd0;
            n_sd = sd + 4'd1;
            if (sd == 4'd5) begin
                n_sd = 4'd0;
                n_mo = mo + 4'd1;
                if (mo == 4'd9) begin
                    n_mo = 4'd0;
                    n_md = md + 4'd1;
                    if (md == 4'd5) begin
                        n_md = 4'd0;
                        if ((hd == 4'd2) && (ho == 4'd3)) begin
                            n_hd = 4'd0;
                            n_ho = 4'd0;
                        end else if (ho == 4'd9) begin
                            n_ho = 4'd0;
                            n_hd = hd + 4'd1;
                        end else begin
                            n_ho = ho + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Time registers: a valid load wins over a coincident second tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {hd, ho, md, mo, sd, so} <= '0;
        end else if (load_ok) begin
            {hd, ho, md, mo} <= time_init_bcd;
            {sd, so}         <= 8'h00;
        end else if (sec_tick) begin
            {hd, ho, md, mo, sd, so} <= {n_hd, n_ho, n_md, n_mo, n_sd, n_so};
        end
    end

    // Minute-roll strobe: set only when counting (not loading) produces SS=00
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            roll_vld_p1 <= 1'b0;
        end else begin
            roll_vld_p1 <= sec_tick && !load_ok && (sd == 4'd5) && (so == 4'd9);
        end
    end

    // Alarm registers and configuration-error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                alarm_reg[i] <= 16'h0000;
            end
            cfg_err <= 1'b0;
        end else begin
            if (wr_ok) begin
                alarm_reg[alarm_wr_idx] <= alarm_wr_bcd;
            end
            cfg_err <= (time_load && !load_ok) || (alarm_wr && !wr_ok);
        end
    end

    // --- stage p1: compare the freshly rolled minute against enabled channels
    // Descending scan so the lowest matching channel index is the one kept
    always_comb begin
        hit     = '0;
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            hit[i] = roll_vld_p1 && alarm_en[i] && (alarm_reg[i] == time_now_bcd);
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Ring FSM next-state: stop beats snooze, disabling the active channel aborts
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        idx_nxt   = ring_idx;
        case (state)
            IDLE: begin
                if (hit_any) begin
                    state_nxt = RINGING;
                    tmr_nxt   = RING_LD;
                    idx_nxt   = hit_idx;
                end
            end
            RINGING: begin
                if (!alarm_en[ring_idx] || stop) begin
                    state_nxt = IDLE;
                end else if (snooze) begin
                    state_nxt = SNOOZED;
                    tmr_nxt   = SNOOZE_LD;
                end else if (sec_tick) begin
                    if (tmr <= TMR_ONE) begin
                        state_nxt = IDLE;
                        tmr_nxt   = '0;
                    end else begin
                        tmr_nxt = tmr - TMR_ONE;
                    end
                end
            end
            SNOOZED: begin
                if (!alarm_en[ring_idx] || stop) begin
                    state_nxt = IDLE;
                end else if (sec_tick) begin
                    if (tmr <= TMR_ONE) begin
                        state_nxt = RINGING;
                        tmr_nxt   = RING_LD;
                    end else begin
                        tmr_nxt = tmr - TMR_ONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // --- stage p2: ring FSM state, timer and triggering channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tmr      <= '0;
            ring_idx <= '0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            ring_idx <= idx_nxt;
        end
    end

endmodule

// File: doc/bcd_alarm_clock_multi.md
Name: bcd_alarm_clock_multi

Overview:
- Parametrised next-generation alarm-clock core: BCD time-of-day counter (HH:MM:SS, 24 h) plus N independently programmable alarm channels.
- Adds a ring/snooze/stop state machine with auto-timeout.
- Sits between the board top (buttons, LEDs, 7-segment) and the clock source.
- Replaces the single fixed-alarm core.

Parameters:
TICKS_PER_SEC, 100_000_000, clk cycles per second (≥2; sims use 4)
N_ALARMS, 4, number of alarm channels (1..16)
SNOOZE_SEC, 300, snooze duration in seconds (≥1)
RING_SEC, 60, ring auto-timeout in seconds (≥1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
time_load  in  1  one-cycle pulse: load time_init_bcd
time_init_bcd  in  16  {hour_dec, hour_one, min_dec, min_one}, BCD
alarm_wr  in  1  one-cycle pulse: write alarm register alarm_wr_idx
alarm_wr_idx  in  $clog2(N_ALARMS) (min 1)  alarm channel to write
alarm_wr_bcd  in  16  alarm HHMM, same packing as time_init_bcd
alarm_en  in  N_ALARMS  per-channel enable (level)
snooze  in  1  one-cycle pulse (debounced upstream)
stop  in  1  one-cycle pulse (debounced upstream)
time_now_bcd  out  16  current HHMM, BCD
sec_now_bcd  out  8  current seconds, BCD
sec_tick  out  1  one-cycle pulse each second
ring  out  1  alarm sounding
snoozed  out  1  in snooze wait
ring_idx  out  $clog2(N_ALARMS) (min 1)  channel that triggered
cfg_err  out  1  one-cycle pulse: rejected load/write

Behaviour:
- Reset (async, rst=1): all outputs 0; time 00:00:00; prescaler 0; all alarm registers 00:00; FSM IDLE.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1.
  - sec_tick is 1 in the cycle where the count equals TICKS_PER_SEC-1.
  - Time digits update at the end of that cycle.
- Counting: BCD per digit.
  - min_one 9→0 carries to min_dec; min_dec 5→0 carries to hours.
  - Hours roll 23→00: 23:59:59 → 00:00:00.
  - No binary intermediate visible on outputs.
- Validation (load and alarm write): reject if any digit >9, min_dec >5, hours >23, or hour_dec >2. Rejected → no state change; cfg_err pulses the next cycle.
- time_load, when valid:
  - Sets HHMM, SS=00, prescaler=0.
  - Has priority over a coincident sec_tick.
  - Never triggers an alarm match.
  - Does not affect the ring FSM.
- alarm_wr, when valid: the register updates the next cycle. A write to the channel currently ringing does not stop it.
- Match:
  - Evaluated only on the sec_tick update that produces SS=00 from counting.
  - Channel i matches if alarm_en[i]=1 and its register equals the new HHMM.
  - Lowest matching index wins; other matches are dropped.
- FSM states IDLE, RINGING, SNOOZED; ring=1 only in RINGING, snoozed=1 only in SNOOZED.
  - IDLE → RINGING on a match. ring and ring_idx are registered one cycle after time_now_bcd shows the match minute. Ring timer is loaded with RING_SEC.
  - RINGING:
    - stop → IDLE.
    - else snooze → SNOOZED, snooze timer loaded with SNOOZE_SEC.
    - else ring timer decrements on sec_tick; reaching 0 → IDLE.
  - SNOOZED:
    - stop → IDLE.
    - snooze ignored.
    - timer decrements on sec_tick; reaching 0 → RINGING, ring timer reloaded.
  - Any non-IDLE state: alarm_en[ring_idx] deasserted → IDLE next cycle. New matches are ignored.
  - stop and snooze in the same cycle: stop wins.
  - ring_idx holds its last value in IDLE.
- Reset mid-ring or mid-snooze: immediate return to IDLE with outputs as at reset.

Test Plan (TICKS_PER_SEC=4, SNOOZE_SEC=3, RING_SEC=5, N_ALARMS=4):
- Reset, run 4 cycles → sec_tick once; sec_now_bcd 8'h01. Load 16'h2359, run 60 s → 00:00:00, sec_now_bcd 8'h00.
- Load 16'h1275 → cfg_err pulse; time unchanged. Alarm write 16'h2400 → cfg_err; register unchanged.
- Alarm ch2=16'h0001, ch1=16'h0001, alarm_en=4'b0110, time 00:00:00, run 60 s → ring=1, ring_idx=1 one cycle after time_now_bcd=16'h0001. No stop → ring falls after 5 sec_ticks.
- Ringing, pulse snooze → ring=0, snoozed=1. After 3 sec_ticks → ring=1 again. Pulse stop and snooze together → IDLE, ring=0, snoozed=0.
- Ringing on ch0, clear alarm_en[0] → ring=0 next cycle. Load 16'h0001 while alarm 0001 is enabled → no ring.
- Assert rst mid-snooze, async → all outputs 0 immediately, time 00:00:00.
